// File: rtl/imul_idiv_wb_ctrl_pkg.sv
// Shared types and constants for the mul/div completion and writeback controller.
package imul_idiv_wb_ctrl_pkg;

  localparam int unsigned data_width     = 32;
  localparam int unsigned reg_addr_width = 5;

  localparam logic [reg_addr_width-1:0] x0_idx = '0;

  typedef enum logic [1:0] {
    st_idle = 2'b00,
    st_busy = 2'b01,
    st_hold = 2'b10
  } state_e;

endpackage

// File: rtl/imul_idiv_wb_ctrl.sv
// Tracks one outstanding mul/div op, takes its result and holds it for the regfile write port.
// Optional macro IMUL_IDIV_WB_BYPASS_EN forwards the result to the write port in the arrival cycle.
module imul_idiv_wb_ctrl
  import imul_idiv_wb_ctrl_pkg::*;
#(
  parameter int unsigned data_width_p     = data_width,
  parameter int unsigned reg_addr_width_p = reg_addr_width
) (
  input  logic                        clk_i,
  input  logic                        reset_i,
  input  logic                        issue_v_i,
  output logic                        issue_ready_o,
  input  logic [reg_addr_width_p-1:0] issue_rd_i,
  input  logic                        md_v_i,
  input  logic [data_width_p-1:0]     md_result_i,
  output logic                        md_yumi_o,
  output logic                        wb_v_o,
  output logic [reg_addr_width_p-1:0] wb_rd_o,
  output logic [data_width_p-1:0]     wb_data_o,
  input  logic                        wb_yumi_i,
  output logic                        pending_v_o,
  output logic [reg_addr_width_p-1:0] pending_rd_o
);

  state_e                      state_r, state_n;
  logic [reg_addr_width_p-1:0] rd_r, rd_n;
  logic [data_width_p-1:0]     data_r, data_n;
  logic                        rd_is_x0;

  assign rd_is_x0 = (rd_r == reg_addr_width_p'(x0_idx));

  // State and payload registers
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_r <= st_idle;
      rd_r    <= '0;
      data_r  <= '0;
    end else begin
      state_r <= state_n;
      rd_r    <= rd_n;
      data_r  <= data_n;
    end
  end

  // Next state and handshake outputs
  always_comb begin
    state_n       = state_r;
    rd_n          = rd_r;
    data_n        = data_r;
    issue_ready_o = 1'b0;
    md_yumi_o     = 1'b0;
    wb_v_o        = 1'b0;
    wb_rd_o       = '0;
    wb_data_o     = '0;
    pending_v_o   = 1'b0;
    pending_rd_o  = '0;

    case (state_r)
      st_idle: begin
        issue_ready_o = 1'b1;
        if (issue_v_i) begin
          rd_n    = issue_rd_i;
          state_n = st_busy;
        end
      end

      st_busy: begin
        pending_v_o  = 1'b1;
        pending_rd_o = rd_r;
        md_yumi_o    = md_v_i;
        if (md_v_i) begin
          data_n = md_result_i;
          // x0 results are consumed but never written back
          if (rd_is_x0) begin
            state_n = st_idle;
          end else begin
`ifdef IMUL_IDIV_WB_BYPASS_EN
            wb_v_o    = 1'b1;
            wb_rd_o   = rd_r;
            wb_data_o = md_result_i;
            state_n   = wb_yumi_i ? st_idle : st_hold;
`else
            state_n   = st_hold;
`endif
          end
        end
      end

      st_hold: begin
        pending_v_o  = 1'b1;
        pending_rd_o = rd_r;
        wb_v_o       = 1'b1;
        wb_rd_o      = rd_r;
        wb_data_o    = data_r;
        if (wb_yumi_i) state_n = st_idle;
      end

      default: state_n = st_idle;
    endcase
  end

  // The unit may only present a result while an op is outstanding here
  md_v_only_in_busy: assert property (
    @(posedge clk_i) disable iff (reset_i) md_v_i |-> (state_r == st_busy)
  );

endmodule

// File: tb/tb_imul_idiv_wb_ctrl.sv
// Directed bench for imul_idiv_wb_ctrl with a writeback scoreboard; honours IMUL_IDIV_WB_BYPASS_EN.
module tb_imul_idiv_wb_ctrl;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } wb_exp_t;

  logic        clk = 1'b0;
  logic        reset_i;
  logic        issue_v_i;
  logic        issue_ready_o;
  logic [4:0]  issue_rd_i;
  logic        md_v_i;
  logic [31:0] md_result_i;
  logic        md_yumi_o;
  logic        wb_v_o;
  logic [4:0]  wb_rd_o;
  logic [31:0] wb_data_o;
  logic        wb_yumi_i;
  logic        pending_v_o;
  logic [4:0]  pending_rd_o;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  wb_exp_t     sb_q[$];

  imul_idiv_wb_ctrl dut (
    .clk_i         (clk),
    .reset_i       (reset_i),
    .issue_v_i     (issue_v_i),
    .issue_ready_o (issue_ready_o),
    .issue_rd_i    (issue_rd_i),
    .md_v_i        (md_v_i),
    .md_result_i   (md_result_i),
    .md_yumi_o     (md_yumi_o),
    .wb_v_o        (wb_v_o),
    .wb_rd_o       (wb_rd_o),
    .wb_data_o     (wb_data_o),
    .wb_yumi_i     (wb_yumi_i),
    .pending_v_o   (pending_v_o),
    .pending_rd_o  (pending_rd_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Inputs change just after the falling edge; outputs are sampled 1ns later
  task automatic next_cycle();
    @(negedge clk);
  endtask

  // Compare the write port against the scoreboard head; retire it when granted
  task automatic sb_mon(input string tag);
    wb_exp_t e;
    if (wb_v_o) begin
      check({tag, " sb_nonempty"}, 64'(sb_q.size() != 0), 64'd1);
      if (sb_q.size() != 0) begin
        e = sb_q[0];
        check({tag, " wb_rd"}, 64'(wb_rd_o), 64'(e.rd));
        check({tag, " wb_data"}, 64'(wb_data_o), 64'(e.data));
        if (wb_yumi_i) void'(sb_q.pop_front());
      end
    end else begin
      check({tag, " wb_rd_zero"}, 64'(wb_rd_o), 64'd0);
      check({tag, " wb_data_zero"}, 64'(wb_data_o), 64'd0);
    end
  endtask

  task automatic issue(input logic [4:0] rd);
    next_cycle();
    issue_v_i  = 1'b1;
    issue_rd_i = rd;
    #1 check("issue ready", 64'(issue_ready_o), 64'd1);
    next_cycle();
    issue_v_i  = 1'b0;
    issue_rd_i = 5'd0;
    #1;
    check("issue pending_v", 64'(pending_v_o), 64'd1);
    check("issue pending_rd", 64'(pending_rd_o), 64'(rd));
    check("issue busy not ready", 64'(issue_ready_o), 64'd0);
  endtask

  task automatic result(input logic [4:0] rd, input logic [31:0] data);
    md_v_i      = 1'b1;
    md_result_i = data;
    if (rd != 5'd0) sb_q.push_back('{rd: rd, data: data});
    #1 check("md_yumi same cycle", 64'(md_yumi_o), 64'd1);
  endtask

  initial begin
    reset_i = 1'b1; issue_v_i = 1'b0; issue_rd_i = '0;
    md_v_i = 1'b0; md_result_i = '0; wb_yumi_i = 1'b0;

    // 1: reset state
    next_cycle(); next_cycle();
    #1;
    check("rst issue_ready", 64'(issue_ready_o), 64'd1);
    check("rst wb_v", 64'(wb_v_o), 64'd0);
    check("rst pending_v", 64'(pending_v_o), 64'd0);
    check("rst pending_rd", 64'(pending_rd_o), 64'd0);
    check("rst md_yumi", 64'(md_yumi_o), 64'd0);
    next_cycle();
    reset_i = 1'b0;

    // 2: normal path, grant held high throughout
    wb_yumi_i = 1'b1;
    issue(5'd5);
    for (int i = 0; i < 9; i++) begin
      next_cycle();
      #1;
      check("t2 wait pending_rd", 64'(pending_rd_o), 64'd5);
      check("t2 wait md_yumi", 64'(md_yumi_o), 64'd0);
      sb_mon("t2 wait");
    end
    next_cycle();
    result(5'd5, 32'hDEADBEEF);
`ifdef IMUL_IDIV_WB_BYPASS_EN
    check("t2 bypass wb_v", 64'(wb_v_o), 64'd1);
`else
    check("t2 no early wb_v", 64'(wb_v_o), 64'd0);
`endif
    sb_mon("t2 md");
    next_cycle();
    md_v_i = 1'b0;
    #1;
`ifndef IMUL_IDIV_WB_BYPASS_EN
    check("t2 hold wb_v", 64'(wb_v_o), 64'd1);
    check("t2 hold pending_rd", 64'(pending_rd_o), 64'd5);
`endif
    sb_mon("t2 hold");
    next_cycle();
    #1;
    check("t2 idle ready", 64'(issue_ready_o), 64'd1);
    check("t2 idle pending_v", 64'(pending_v_o), 64'd0);
    check("t2 idle pending_rd", 64'(pending_rd_o), 64'd0);
    sb_mon("t2 idle");

    // 3: write-port contention; issues during HOLD are refused
    wb_yumi_i = 1'b0;
    issue(5'd7);
    next_cycle();
    result(5'd7, 32'h1);
    sb_mon("t3 md");
    for (int i = 0; i < 4; i++) begin
      next_cycle();
      md_v_i     = 1'b0;
      issue_v_i  = 1'b1;
      issue_rd_i = 5'd12;
      #1;
      check("t3 hold wb_v", 64'(wb_v_o), 64'd1);
      check("t3 hold not ready", 64'(issue_ready_o), 64'd0);
      check("t3 hold pending_rd", 64'(pending_rd_o), 64'd7);
      sb_mon("t3 hold");
    end
    next_cycle();
    issue_v_i = 1'b0; issue_rd_i = '0; wb_yumi_i = 1'b1;
    #1 sb_mon("t3 grant");
    next_cycle();
    wb_yumi_i = 1'b0;
    #1;
    check("t3 idle ready", 64'(issue_ready_o), 64'd1);
    check("t3 idle wb_v", 64'(wb_v_o), 64'd0);

    // 4: x0 destination drops the result
    issue(5'd0);
    next_cycle();
    wb_yumi_i = 1'b1;
    result(5'd0, 32'h55);
    check("t4 md no wb_v", 64'(wb_v_o), 64'd0);
    next_cycle();
    md_v_i = 1'b0; wb_yumi_i = 1'b0;
    #1;
    check("t4 idle ready", 64'(issue_ready_o), 64'd1);
    check("t4 no wb_v", 64'(wb_v_o), 64'd0);
    check("t4 pending_v", 64'(pending_v_o), 64'd0);

    // 5: reset while BUSY
    issue(5'd3);
    next_cycle();
    reset_i = 1'b1;
    #1 check("t5 reset pending before edge", 64'(pending_v_o), 64'd1);
    next_cycle();
    reset_i = 1'b0;
    #1;
    check("t5 idle ready", 64'(issue_ready_o), 64'd1);
    check("t5 pending_v", 64'(pending_v_o), 64'd0);
    check("t5 pending_rd", 64'(pending_rd_o), 64'd0);
    check("t5 md_yumi", 64'(md_yumi_o), 64'd0);

    // 6: result arriving together with the grant
    wb_yumi_i = 1'b1;
    issue(5'd9);
    next_cycle();
    result(5'd9, 32'hCAFE);
`ifdef IMUL_IDIV_WB_BYPASS_EN
    check("t6 bypass wb_v", 64'(wb_v_o), 64'd1);
`else
    check("t6 no bypass wb_v", 64'(wb_v_o), 64'd0);
`endif
    sb_mon("t6 md");
    next_cycle();
    md_v_i = 1'b0;
    #1;
`ifdef IMUL_IDIV_WB_BYPASS_EN
    check("t6 ready next cycle", 64'(issue_ready_o), 64'd1);
`else
    check("t6 hold wb_v", 64'(wb_v_o), 64'd1);
    check("t6 hold not ready", 64'(issue_ready_o), 64'd0);
`endif
    sb_mon("t6 after");
    next_cycle();
    wb_yumi_i = 1'b0;
    #1;
    check("t6 final ready", 64'(issue_ready_o), 64'd1);
    check("sb drained", 64'(sb_q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/imul_idiv_wb_ctrl.md
Name: imul_idiv_wb_ctrl

Overview:
Downstream completion and writeback controller for the iterative integer multiply/divide unit.
- Records the destination register when an M-extension op is issued to the unit.
- Consumes the unit's result through its valid/yumi handshake.
- Holds the result until the register-file write port grants it.
- Exports a pending-rd scoreboard entry so the pipeline can stall dependent instructions.

Parameters:
data_width_p, 32, width of result and writeback data
reg_addr_width_p, 5, register index width

Ports:
clk_i  input  1  clock
reset_i  input  1  synchronous active-high reset
issue_v_i  input  1  pipeline issues an op to the mul/div unit this cycle
issue_ready_o  output  1  controller can accept a new issue
issue_rd_i  input  reg_addr_width_p  destination register of the issued op
md_v_i  input  1  mul/div result valid
md_result_i  input  data_width_p  mul/div result
md_yumi_o  output  1  result consumed; drives the unit's yumi
wb_v_o  output  1  writeback request
wb_rd_o  output  reg_addr_width_p  writeback register index
wb_data_o  output  data_width_p  writeback data
wb_yumi_i  input  1  register-file port grants writeback
pending_v_o  output  1  an op is outstanding (BUSY or HOLD)
pending_rd_o  output  reg_addr_width_p  rd of the outstanding op

Behaviour:
- One clock (clk_i); reset_i is synchronous, active-high.
- States:
  - IDLE: no op outstanding.
  - BUSY: op issued, waiting for md_v_i.
  - HOLD: result captured, waiting for wb_yumi_i.
- Reset: state=IDLE, rd_r=0, data_r=0. Outputs: issue_ready_o=1, md_yumi_o=0, wb_v_o=0, pending_v_o=0, pending_rd_o=0.
- issue_ready_o = (state==IDLE).
- Issue fire = issue_v_i & issue_ready_o. On fire: rd_r<=issue_rd_i; state IDLE->BUSY.
- issue_v_i while not ready is ignored and has no state effect. The pipeline must stall on that condition.
- BUSY:
  - md_yumi_o = md_v_i (same cycle, combinational).
  - On md_v_i: data_r<=md_result_i.
  - If rd_r!=0: state->HOLD.
  - If rd_r==0: state->IDLE and no writeback (x0 writes dropped).
- HOLD:
  - wb_v_o=1, wb_rd_o=rd_r, wb_data_o=data_r.
  - wb_yumi_i -> IDLE.
  - wb_v_o and its outputs stay stable until granted.
  - md_yumi_o=0.
- md_v_i in IDLE or HOLD is a protocol error: md_yumi_o=0, no state change. Flag with an assertion.
- wb_yumi_i without wb_v_o is a protocol error and is ignored.
- wb_rd_o and wb_data_o are zero whenever wb_v_o=0, unless bypass is active (see Optional Feature).
- pending_v_o = (state!=IDLE). pending_rd_o = rd_r when pending_v_o, else 0.
- Latency, no bypass: md_v_i at cycle N -> wb_v_o at N+1 -> earliest return to IDLE at N+2. A new issue can be accepted at N+2.
- Reset mid-operation: returns to IDLE and discards the held result. The mul/div unit shares reset_i, so no orphan result follows.

Optional Feature:
Macro IMUL_IDIV_WB_BYPASS_EN.
- Defined, in BUSY with md_v_i and rd_r!=0:
  - wb_v_o=1 combinationally, wb_rd_o=rd_r, wb_data_o=md_result_i.
  - If wb_yumi_i the same cycle: state->IDLE directly and HOLD is skipped. Latency md_v_i -> IDLE is 1 cycle.
  - Otherwise: capture to data_r and go to HOLD as normal.
- Undefined: wb_v_o is driven only from HOLD, as above.

Decomposition:
- Shared package:
  - state enum: IDLE=2'b00, BUSY=2'b01, HOLD=2'b10.
  - reg_addr_width and data_width localparams.
  - x0 index constant.
- No sub-module. Single FSM plus rd/data registers, roughly 150 lines.

Test Plan:
1. Reset with all inputs 0 -> issue_ready_o=1, wb_v_o=0, pending_v_o=0, md_yumi_o=0.
2. Normal path, no bypass:
   - Stimulus: issue rd=5; md_v_i with 32'hDEADBEEF 10 cycles later; wb_yumi_i held high.
   - Response: md_yumi_o same cycle as md_v_i; wb_v_o next cycle with rd=5, data=DEADBEEF; pending_v_o/pending_rd_o=5 throughout; IDLE after grant.
3. Write-port contention:
   - Stimulus: issue rd=7, result 32'h1; wb_yumi_i low for 4 cycles.
   - Response: wb_v_o/rd=7/data=1 stable all 4 cycles; issue_v_i during HOLD not accepted; grant -> IDLE.
4. x0 destination: issue rd=0, result 32'h55 -> md_yumi_o pulses, wb_v_o never asserts, IDLE next cycle.
5. Reset mid-op: issue rd=3, assert reset_i in BUSY -> next cycle IDLE, pending_v_o=0; a later md_v_i is not consumed.
6. With IMUL_IDIV_WB_BYPASS_EN: issue rd=9; md_v_i and wb_yumi_i both high with 32'hCAFE -> wb_v_o same cycle, data=CAFE, issue_ready_o=1 next cycle.
